// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: streams operands LSB-first through a single
// one-bit full-add cell, one bit per clock, with a registered carry.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] opa, opb;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             sum_bit, carry_nx;
  logic             last;

  // One-bit full-add cell: returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

  always_comb begin
    {carry_nx, sum_bit} = full_add(opa[0], opb[0], carry);
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ADD;
      ADD:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they stay glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == ADD);
      done  <= (state_nx == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            opa   <= A;
            opb   <= B;
            carry <= Cin;
            cnt   <= '0;
            S     <= '0;
          end
        end
        ADD: begin
          carry <= carry_nx;
          S     <= {sum_bit, S[WIDTH-1:1]};
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          cnt   <= cnt + 1'b1;
          if (last) Cout <= carry_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8 and WIDTH=5; expected
// results come from plain integer addition A+B+Cin.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       rst8, start8, cin8, cout8, busy8, done8;
  logic [7:0] a8, b8, s8;
  logic       rst5, start5, cin5, cout5, busy5, done5;
  logic [4:0] a5, b5, s5;

  logic [8:0] q8[$];
  logic [5:0] q5[$];

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .S(s8), .Cout(cout8), .busy(busy8), .done(done8)
  );

  serial_adder_ctrl #(.WIDTH(5)) u5 (
    .clk(clk), .reset(rst5), .start(start5), .A(a5), .B(b5), .Cin(cin5),
    .S(s5), .Cout(cout5), .busy(busy5), .done(done5)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitors: pop the expected result whenever a DUT reports done.
  always @(negedge clk) begin
    if (done8) begin
      chk("busy_done_excl8", 64'(busy8), 64'd0);
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done8 actual=%0h required=none", {cout8, s8});
      end else begin
        chk("sum8", 64'({cout8, s8}), 64'(q8.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (done5) begin
      chk("busy_done_excl5", 64'(busy5), 64'd0);
      if (q5.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done5 actual=%0h required=none", {cout5, s5});
      end else begin
        chk("sum5", 64'({cout5, s5}), 64'(q5.pop_front()));
      end
    end
  end

  task automatic wait_idle8();
    int guard = 0;
    @(negedge clk);
    while ((busy8 || done8) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("idle_timeout8", 64'(guard), 64'd0);
  endtask

  task automatic wait_idle5();
    int guard = 0;
    @(negedge clk);
    while ((busy5 || done5) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("idle_timeout5", 64'(guard), 64'd0);
  endtask

  // k counts negedges after the accepted start edge (k=0 is right after edge 0).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin);
    int k;
    int nb;
    wait_idle8();
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    @(posedge clk);
    q8.push_back(9'(a) + 9'(b) + 9'(cin));
    @(negedge clk);
    start8 = 1'b0;
    k = 0;
    nb = 0;
    while (!done8 && k < 40) begin
      if (busy8) nb++;
      @(negedge clk);
      k++;
    end
    chk("latency8", 64'(k), 64'd8);
    chk("busy_cycles8", 64'(nb), 64'd8);
  endtask

  task automatic op5(input logic [4:0] a, input logic [4:0] b, input logic cin);
    int k;
    wait_idle5();
    a5 = a; b5 = b; cin5 = cin; start5 = 1'b1;
    @(posedge clk);
    q5.push_back(6'(a) + 6'(b) + 6'(cin));
    @(negedge clk);
    start5 = 1'b0;
    k = 0;
    while (!done5 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("latency5", 64'(k), 64'd5);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d1, d2, nd;
    rst8 = 1'b1; rst5 = 1'b1;
    start8 = 1'b1; start5 = 1'b1;
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    a5 = 5'h1F; b5 = 5'h01; cin5 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state8", 64'({s8, cout8, busy8, done8}), 64'd0);
    chk("reset_state5", 64'({s5, cout5, busy5, done5}), 64'd0);
    rst8 = 1'b0; rst5 = 1'b0; start8 = 1'b0; start5 = 1'b0;

    // Basic operation and carry extremes.
    op8(8'h35, 8'h4A, 1'b0);
    chk("t1_S", 64'(s8), 64'h7F);
    op8(8'hFF, 8'h01, 1'b0);
    chk("t2a_S_Cout", 64'({cout8, s8}), 64'h100);
    op8(8'hFF, 8'hFF, 1'b1);
    chk("t2b_S_Cout", 64'({cout8, s8}), 64'h1FF);
    repeat (3) @(negedge clk);
    chk("hold_after_done", 64'({cout8, s8}), 64'h1FF);

    // Start pulsed while busy must be ignored.
    wait_idle8();
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    q8.push_back(9'h047);
    k = 0;
    do begin
      @(negedge clk);
      if (k == 0) start8 = 1'b0;
      if (k == 3) begin start8 = 1'b1; a8 = 8'h11; b8 = 8'h11; end
      if (k == 4) start8 = 1'b0;
      k++;
    end while (!done8 && k < 40);
    chk("t3_latency", 64'(k - 1), 64'd8);
    repeat (14) @(negedge clk);
    chk("t3_queue_empty", 64'(q8.size()), 64'd0);

    // Reset mid-ADD at cnt=3.
    wait_idle8();
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    q8.push_back(9'h100);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    q8.delete();
    @(negedge clk);
    chk("t4_reset_outputs", 64'({s8, cout8, busy8, done8}), 64'd0);
    rst8 = 1'b0;
    repeat (12) @(negedge clk);
    op8(8'h01, 8'h02, 1'b0);
    chk("t4_after_reset_S", 64'({cout8, s8}), 64'h003);

    // Start held high across two operations; operands change during ADD.
    wait_idle8();
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1; start8 = 1'b1;
    @(posedge clk);
    q8.push_back(9'h101);
    q8.push_back(9'h083);
    d1 = -1; d2 = -1; nd = 0;
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) begin a8 = 8'h7E; b8 = 8'h05; cin8 = 1'b0; end
      if (done8) begin
        if (nd == 0) d1 = j; else d2 = j;
        nd++;
      end
      if (j == 10) start8 = 1'b0;
    end
    chk("t5_done_count", 64'(nd), 64'd2);
    chk("t5_first_done", 64'(d1), 64'd8);
    chk("t5_second_done", 64'(d2), 64'd18);

    // Random sweep on both widths in parallel.
    fork
      for (int i = 0; i < 1000; i++)
        op8(8'($urandom), 8'($urandom), 1'($urandom));
      for (int i = 0; i < 1000; i++)
        op5(5'($urandom), 5'($urandom), 1'($urandom));
    join
    repeat (4) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q5_drained", 64'(q5.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
